// File: rtl/anneal_scheduler.sv
// Purpose: sequences an annealing run (N spins x S sweeps) into a stream of flip decisions.
// Latency: 1 cycle from SAMPLE entry to flip_valid; SETTLE/SAMPLE bubble between decisions.
// Backpressure: valid/ready on the flip port; decision held stable until flip_ready.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, abort          run control (start sampled in IDLE only, abort ignored in IDLE)
//   cfg_*                 run configuration, latched when start is accepted
//   sel_in                registered select from the perturb selector
//   perturb_prob          probability driven to the perturb selector (per sweep)
//   sel_seed, sel_rst     reseed pulse for the perturb selector
//   flip_valid/ready      handshake for flip_idx/flip_en decisions
//   sweep_idx             current sweep number
//   busy, done            status; done pulses once at normal completion
module anneal_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_spins,
  input  logic [7:0] cfg_sweeps,
  input  logic [7:0] cfg_prob_init,
  input  logic [7:0] cfg_prob_step,
  input  logic [7:0] cfg_prob_min,
  input  logic [7:0] cfg_seed,
  input  logic       sel_in,
  output logic [7:0] perturb_prob,
  output logic [7:0] sel_seed,
  output logic       sel_rst,
  output logic       flip_valid,
  input  logic       flip_ready,
  output logic [7:0] flip_idx,
  output logic       flip_en,
  output logic [7:0] sweep_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    ISSUE  = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Latched run configuration (the initial probability lives in perturb_prob).
  logic [7:0] spins_q;
  logic [7:0] sweeps_q;
  logic [7:0] step_q;
  logic [7:0] min_q;
  logic [7:0] seed_q;

  logic       accept;
  logic       empty_run;
  logic       abort_run;
  logic       hs;
  logic       last_spin;
  logic       last_sweep;
  logic [8:0] floor_plus_step;
  logic [7:0] prob_next;

  // ---------------------------------------------------------------
  // Next-state and decoded outputs
  // ---------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    empty_run  = (cfg_spins == 8'd0) || (cfg_sweeps == 8'd0);
    abort_run  = abort && (state_q != IDLE);
    hs         = (state_q == ISSUE) && flip_valid && flip_ready;
    last_spin  = (flip_idx == spins_q - 8'd1);
    last_sweep = (sweep_idx == sweeps_q - 8'd1);

    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = empty_run ? FIN : SEED;
        end
      end
      SEED:   state_d = SETTLE;
      SETTLE: state_d = SAMPLE;
      SAMPLE: state_d = ISSUE;
      ISSUE: begin
        if (hs) begin
          if (!last_spin)      state_d = SAMPLE;
          else if (last_sweep) state_d = FIN;
          else                 state_d = SETTLE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition out of a busy state.
    if (abort_run) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decoded from state are qualified with abort so an aborted
  // SEED or FIN cycle never leaks a reseed or completion pulse.
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN) && !abort;
  assign sel_rst  = (state_q == SEED) && !abort;
  assign sel_seed = sel_rst ? seed_q : 8'd0;

  // ---------------------------------------------------------------
  // Probability decay: computed one bit wider so min+step cannot wrap;
  // the result never drops below the floor and never increases.
  // ---------------------------------------------------------------
  assign floor_plus_step = {1'b0, min_q} + {1'b0, step_q};

  always_comb begin
    prob_next = perturb_prob;
    if ({1'b0, perturb_prob} >= floor_plus_step) begin
      prob_next = perturb_prob - step_q;
    end else if (perturb_prob > min_q) begin
      prob_next = min_q;
    end
  end

  // ---------------------------------------------------------------
  // Datapath and configuration registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      spins_q      <= 8'd0;
      sweeps_q     <= 8'd0;
      step_q       <= 8'd0;
      min_q        <= 8'd0;
      seed_q       <= 8'd0;
      perturb_prob <= 8'd0;
      flip_idx     <= 8'd0;
      sweep_idx    <= 8'd0;
      flip_en      <= 1'b0;
      flip_valid   <= 1'b0;
    end else if (abort_run) begin
      flip_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            spins_q  <= cfg_spins;
            sweeps_q <= cfg_sweeps;
            step_q   <= cfg_prob_step;
            min_q    <= cfg_prob_min;
            seed_q   <= cfg_seed;
            if (!empty_run) begin
              perturb_prob <= cfg_prob_init;
              flip_idx     <= 8'd0;
              sweep_idx    <= 8'd0;
            end
          end
        end
        SAMPLE: begin
          flip_en    <= sel_in;
          flip_valid <= 1'b1;
        end
        ISSUE: begin
          if (hs) begin
            flip_valid <= 1'b0;
            if (!last_spin) begin
              flip_idx <= flip_idx + 8'd1;
            end else if (!last_sweep) begin
              // Sweep boundary: the only place the probability moves mid-run.
              flip_idx     <= 8'd0;
              sweep_idx    <= sweep_idx + 8'd1;
              perturb_prob <= prob_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anneal_scheduler.sv
// Purpose: randomized self-checking bench for anneal_scheduler against a run-level model.
// Latency: model expects a decision list of N*S entries and done one cycle after the last handshake.
// Backpressure: flip_ready randomly throttled; held decisions must stay stable.
module tb_anneal_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] cfg_spins;
  logic [7:0] cfg_sweeps;
  logic [7:0] cfg_prob_init;
  logic [7:0] cfg_prob_step;
  logic [7:0] cfg_prob_min;
  logic [7:0] cfg_seed;
  logic       sel_in;
  logic [7:0] perturb_prob;
  logic [7:0] sel_seed;
  logic       sel_rst;
  logic       flip_valid;
  logic       flip_ready;
  logic [7:0] flip_idx;
  logic       flip_en;
  logic [7:0] sweep_idx;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  anneal_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_spins     (cfg_spins),
    .cfg_sweeps    (cfg_sweeps),
    .cfg_prob_init (cfg_prob_init),
    .cfg_prob_step (cfg_prob_step),
    .cfg_prob_min  (cfg_prob_min),
    .cfg_seed      (cfg_seed),
    .sel_in        (sel_in),
    .perturb_prob  (perturb_prob),
    .sel_seed      (sel_seed),
    .sel_rst       (sel_rst),
    .flip_valid    (flip_valid),
    .flip_ready    (flip_ready),
    .flip_idx      (flip_idx),
    .flip_en       (flip_en),
    .sweep_idx     (sweep_idx),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_done"},  done, 0);
    check_eq({tag, "_valid"}, flip_valid, 0);
    check_eq({tag, "_selrst"}, sel_rst, 0);
    check_eq({tag, "_seed"},  sel_seed, 0);
    check_eq({tag, "_prob"},  perturb_prob, 0);
    check_eq({tag, "_idx"},   flip_idx, 0);
    check_eq({tag, "_sweep"}, sweep_idx, 0);
    check_eq({tag, "_en"},    flip_en, 0);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!flip_valid && k < 100);
    check_eq({tag, "_valid"}, flip_valid, 1);
  endtask

  // Full run from the current negedge: the model lists every expected
  // decision (spin, sweep, probability) up front, then the monitor walks it.
  task automatic do_run(input int n, input int s, input int init, input int st,
                        input int mn, input int seed, input int rdy_pct, input bit noise);
    int  exp_idx[$];
    int  exp_sw[$];
    int  exp_pr[$];
    int  p;
    int  hs_cnt, rst_cnt, done_cnt, last_hs, h_idx, h_en, total;
    bit  pending, fin, prev_sel;

    p = init;
    for (int w = 0; w < s; w++) begin
      for (int i = 0; i < n; i++) begin
        exp_idx.push_back(i);
        exp_sw.push_back(w);
        exp_pr.push_back(p);
      end
      if (p >= mn + st)  p = p - st;
      else if (p > mn)   p = mn;
    end
    total = n * s;

    cfg_spins     = n[7:0];
    cfg_sweeps    = s[7:0];
    cfg_prob_init = init[7:0];
    cfg_prob_step = st[7:0];
    cfg_prob_min  = mn[7:0];
    cfg_seed      = seed[7:0];
    start         = 1'b1;

    hs_cnt = 0; rst_cnt = 0; done_cnt = 0; last_hs = 0;
    h_idx = 0; h_en = 0; pending = 1'b0; fin = 1'b0;

    for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      @(negedge clk);
      prev_sel   = sel_in;
      start      = noise ? ($urandom_range(3) == 0) : 1'b0;
      flip_ready = ($urandom_range(99) < rdy_pct);
      sel_in     = $urandom_range(1);
      if (noise) begin
        cfg_spins     = $urandom;
        cfg_sweeps    = $urandom;
        cfg_prob_init = $urandom;
        cfg_prob_step = $urandom;
        cfg_prob_min  = $urandom;
        cfg_seed      = $urandom;
      end
      #1;
      check_eq("busy_run", busy, 1);
      if (sel_rst) begin
        rst_cnt++;
        check_eq("sel_rst_cycle", cyc, 1);
        check_eq("sel_seed", sel_seed, seed);
      end
      if (done) begin
        done_cnt++;
        fin = 1'b1;
        check_eq("done_latency", cyc, last_hs + 1);
        check_eq("flips_left", exp_idx.size(), 0);
        check_eq("valid_at_done", flip_valid, 0);
      end else if (flip_valid) begin
        if (!pending) begin
          if (exp_idx.size() == 0) begin
            check_eq("extra_flip", 1, 0);
          end else begin
            check_eq("flip_idx",  flip_idx,     exp_idx[0]);
            check_eq("sweep_idx", sweep_idx,    exp_sw[0]);
            check_eq("prob",      perturb_prob, exp_pr[0]);
            check_eq("flip_en",   flip_en,      prev_sel);
          end
          h_idx   = flip_idx;
          h_en    = flip_en;
          pending = 1'b1;
        end else begin
          check_eq("hold_idx", flip_idx, h_idx);
          check_eq("hold_en",  flip_en,  h_en);
        end
        if (flip_ready) begin
          pending = 1'b0;
          hs_cnt++;
          last_hs = cyc;
          if (exp_idx.size() > 0) begin
            void'(exp_idx.pop_front());
            void'(exp_sw.pop_front());
            void'(exp_pr.pop_front());
          end
        end
      end else if (pending) begin
        check_eq("valid_dropped", 0, 1);
        pending = 1'b0;
      end
    end

    check_eq("run_finished", fin, 1);
    check_eq("handshakes", hs_cnt, total);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("reseeds", rst_cnt, (total > 0) ? 1 : 0);

    @(negedge clk);
    start = 1'b0;
    flip_ready = 1'b0;
    #1;
    check_eq("idle_busy", busy, 0);
    check_eq("idle_done", done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_hold;
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    cfg_spins = 8'd3; cfg_sweeps = 8'd2; cfg_prob_init = 8'd200;
    cfg_prob_step = 8'd50; cfg_prob_min = 8'd0; cfg_seed = 8'h11;
    sel_in = 1'b0; flip_ready = 1'b0;

    // Reset dominates start/abort.
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");

    // First start accepted in the first cycle after reset releases.
    @(negedge clk);
    rst = 1'b0; abort = 1'b0;
    do_run(3, 2, 200, 50, 0, 8'hA5, 100, 1'b0);

    @(negedge clk);
    do_run(2, 3, 60, 50, 20, 8'h3C, 100, 1'b0);
    @(negedge clk);
    do_run(2, 3, 10, 50, 20, 8'h77, 60, 1'b0);
    @(negedge clk);
    do_run(0, 5, 100, 1, 0, 8'h01, 100, 1'b0);
    @(negedge clk);
    do_run(4, 0, 100, 1, 0, 8'h02, 100, 1'b0);
    @(negedge clk);
    do_run(1, 1, 255, 255, 0, 8'hFF, 50, 1'b1);

    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      do_run($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 255),
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(20, 100), 1'b1);
    end

    // Stall, then abort while the second decision is presented.
    @(negedge clk);
    cfg_spins = 8'd3; cfg_sweeps = 8'd2; cfg_prob_init = 8'd90;
    cfg_prob_step = 8'd10; cfg_prob_min = 8'd0; cfg_seed = 8'h5A;
    flip_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("ab_sel_rst", sel_rst, 1);
    wait_valid("ab0");
    check_eq("ab_idx0", flip_idx, 0);
    en_hold = flip_en;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      sel_in = ~sel_in;
      #1;
      check_eq("stall_valid", flip_valid, 1);
      check_eq("stall_idx", flip_idx, 0);
      check_eq("stall_en", flip_en, en_hold);
    end
    @(negedge clk);
    flip_ready = 1'b1;
    @(negedge clk);
    flip_ready = 1'b0;
    #1;
    check_eq("one_hs_valid", flip_valid, 0);
    wait_valid("ab1");
    check_eq("ab_idx1", flip_idx, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check_eq("ab_busy", busy, 0);
    check_eq("ab_valid", flip_valid, 0);
    check_eq("ab_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_eq("ab_no_done", done, 0);
    end

    // start with abort in IDLE: start wins and the run reseeds from index 0.
    @(negedge clk);
    cfg_seed = 8'h33; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check_eq("rs_busy", busy, 1);
    check_eq("rs_sel_rst", sel_rst, 1);
    check_eq("rs_sel_seed", sel_seed, 8'h33);
    wait_valid("rs");
    check_eq("rs_idx", flip_idx, 0);
    check_eq("rs_sweep", sweep_idx, 0);

    // Reset mid-run clears everything by the next cycle.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    do_run(3, 2, 200, 50, 0, 8'h42, 70, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/anneal_scheduler.md
ANNEAL_SCHEDULER -- requirements
Module: anneal_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 start  input  1  single-cycle request to begin a run; sampled in IDLE only.
REQ-003 abort  input  1  terminates a run; returns to IDLE without asserting done.
REQ-004 cfg_spins  input  8  spins per sweep (N); latched on accepted start.
REQ-005 cfg_sweeps  input  8  sweep count (S); latched on accepted start.
REQ-006 cfg_prob_init  input  8  first-sweep perturbation probability; latched on accepted start.
REQ-007 cfg_prob_step  input  8  per-sweep probability decrement; latched on accepted start.
REQ-008 cfg_prob_min  input  8  probability floor; latched on accepted start.
REQ-009 cfg_seed  input  8  LFSR seed; latched on accepted start.
REQ-010 sel_in  input  1  registered select from the perturb selector.
REQ-011 perturb_prob  output  8  probability driven to the perturb selector.
REQ-012 sel_seed  output  8  seed driven to the perturb selector.
REQ-013 sel_rst  output  1  reset/reseed pulse driven to the perturb selector.
REQ-014 flip_valid  output  1  a flip decision is presented downstream.
REQ-015 flip_ready  input  1  downstream accepts the decision.
REQ-016 flip_idx  output  8  spin index of the presented decision.
REQ-017 flip_en  output  1  1 = perturb this spin; 0 = keep it.
REQ-018 sweep_idx  output  8  current sweep number.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse at normal run completion.

Function
REQ-021 The state machine SHALL use these states: IDLE, SEED, SETTLE, SAMPLE, ISSUE, FIN.
REQ-022 IDLE + start: latch all cfg_*. If N==0 or S==0 -> FIN. Otherwise -> SEED, with perturb_prob=cfg_prob_init, flip_idx=0, sweep_idx=0.
REQ-023 SEED: sel_rst=1 and sel_seed=latched seed for exactly one cycle; -> SETTLE.
REQ-024 SETTLE: one cycle, so that sel_in reflects the current perturb_prob; -> SAMPLE.
REQ-025 SAMPLE: flip_en <= sel_in and flip_valid <= 1; -> ISSUE. Latency from SAMPLE entry to flip_valid is 1 cycle.
REQ-026 ISSUE: flip_valid, flip_en and flip_idx SHALL be held stable until flip_valid && flip_ready.
REQ-027 On the ISSUE handshake, flip_valid <= 0. If flip_idx < N-1: flip_idx+1 -> SAMPLE.
REQ-028 On the ISSUE handshake with flip_idx == N-1 and sweep_idx == S-1: -> FIN.
REQ-029 On the ISSUE handshake with flip_idx == N-1 and sweep_idx < S-1: flip_idx <= 0, sweep_idx+1, probability update, -> SETTLE.
REQ-030 Probability update SHALL be evaluated at 9 bits:
  - if prob >= min+step: prob-step
  - else if prob > min: min
  - else prob unchanged
  - no wrap, never increases.
REQ-031 FIN: done=1 for one cycle; -> IDLE. The latched configuration is retained.
REQ-032 start while busy SHALL be ignored; cfg_* changes while busy SHALL have no effect.
REQ-033 abort SHALL take priority over every other transition in any non-IDLE state: next state IDLE, flip_valid=0, done=0, sel_rst=0.
REQ-034 abort and start together in IDLE: start wins; abort is ignored in IDLE.
REQ-035 flip_ready asserted while flip_valid=0 SHALL be ignored.
REQ-036 perturb_prob SHALL change only on start acceptance and sweep boundaries.
REQ-037 Total flips per run SHALL be N*S; the last flip is flip_idx=N-1, sweep_idx=S-1.

Reset
REQ-038 rst SHALL force state IDLE and all outputs to 0 (perturb_prob, sel_seed, flip_idx, sweep_idx, flip_en, flip_valid, busy, done, sel_rst) and clear all latched configuration, including mid-run.
REQ-039 rst SHALL take priority over start and abort; the first start is accepted on the first cycle after rst deasserts.

Verification
REQ-040 N=3, S=2, init=200, step=50, min=0, flip_ready=1 -> 6 handshakes (idx 0,1,2,0,1,2); perturb_prob 200 then 150; done one cycle after the 6th handshake.
REQ-041 init=60, step=50, min=20, S=3 -> perturb_prob sequence 60, 20, 20; init=10, min=20 -> 10 held for all sweeps.
REQ-042 flip_ready low for 5 cycles during ISSUE -> flip_valid, flip_idx and flip_en stable for all 5 cycles; exactly one handshake counted.
REQ-043 start with N=0 -> busy for one cycle, done pulse, no flip_valid, no sel_rst.
REQ-044 abort during ISSUE at idx 1 -> next cycle IDLE, flip_valid=0, no done; a new start then reseeds (sel_rst pulse) and restarts at idx 0.
REQ-045 rst asserted mid-sweep -> next cycle all outputs 0 and state IDLE; start while busy (sweep 0) -> no restart and no extra flips.
